// File: rtl/ycbcr422_rx.sv
// ycbcr422_rx: receive-side sink for an 8-bit YCbCr 4:2:2 byte stream.
// Regroups Y0,Cb,Y1,Cr into pixel pairs, counts bytes per line and lines
// per frame, and publishes per-frame health at each vs rising edge.
// Optional build macro: RX_CHECKSUM_EN adds a 16-bit per-frame byte sum;
// without it checksum is tied to zero.
module ycbcr422_rx #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic        de,
  input  logic [7:0]  data,
  output logic        pair_valid,
  output logic [7:0]  pair_y0,
  output logic [7:0]  pair_y1,
  output logic [7:0]  pair_cb,
  output logic [7:0]  pair_cr,
  output logic [9:0]  pair_x,
  output logic [8:0]  line_num,
  output logic        frame_done,
  output logic [11:0] frame_lines,
  output logic        frame_ok,
  output logic        phase_err,
  output logic        len_err,
  output logic [15:0] checksum
);

  localparam logic [11:0] H_EXP = 12'(H_ACTIVE);
  localparam logic [11:0] V_EXP = 12'(V_ACTIVE);

  logic        hs_q, vs_q, de_q, vs_d, de_d;
  logic [7:0]  data_q;
  logic [1:0]  ph;
  logic [11:0] bcnt;
  logic [9:0]  pcnt;
  logic [11:0] lcnt;
  logic [7:0]  y0_h, cb_h, y1_h;
  logic        phase_acc, len_acc, seen_fs;
  logic        eol, fs;
  logic        phase_nxt, len_nxt;
  logic [11:0] lines_nxt;
  logic        unused_hs;

  // hs is only carried through the input register
  assign unused_hs = hs_q;

  assign eol = de_d & ~de_q;
  assign fs  = vs_q & ~vs_d;

  // line_num shows the running line count, clamped to its 9-bit range
  assign line_num = (lcnt > 12'd511) ? 9'd511 : lcnt[8:0];

  // End-of-line accounting merged in front of the frame publish, so a line
  // closing on the frame-start cycle lands in the frame being published
  always_comb begin
    phase_nxt = phase_acc;
    len_nxt   = len_acc;
    lines_nxt = lcnt;
    if (eol) begin
      if (ph != 2'd0)     phase_nxt = 1'b1;
      if (bcnt != H_EXP)  len_nxt   = 1'b1;
      if (lcnt != 12'hFFF) lines_nxt = lcnt + 12'd1;
    end
  end

  // Input register stage plus one-cycle delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0; data_q <= 8'h00;
      vs_d <= 1'b0; de_d <= 1'b0;
    end else begin
      hs_q <= hs; vs_q <= vs; de_q <= de; data_q <= data;
      vs_d <= vs_q; de_d <= de_q;
    end
  end

  // Byte phase, byte count and pair assembly within a line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph <= 2'd0; bcnt <= 12'd0; pcnt <= 10'd0;
      y0_h <= 8'h00; cb_h <= 8'h00; y1_h <= 8'h00;
      pair_valid <= 1'b0; pair_x <= 10'd0;
      pair_y0 <= 8'h00; pair_cb <= 8'h00; pair_y1 <= 8'h00; pair_cr <= 8'h00;
    end else begin
      pair_valid <= 1'b0;
      if (de_q) begin
        ph <= ph + 2'd1;
        if (bcnt != 12'hFFF) bcnt <= bcnt + 12'd1;
        case (ph)
          2'd0: y0_h <= data_q;
          2'd1: cb_h <= data_q;
          2'd2: y1_h <= data_q;
          default: begin
            pair_y0    <= y0_h;
            pair_cb    <= cb_h;
            pair_y1    <= y1_h;
            pair_cr    <= data_q;
            pair_x     <= pcnt;
            pair_valid <= 1'b1;
            pcnt       <= pcnt + 10'd1;
          end
        endcase
      end else begin
        ph <= 2'd0;
      end
      if (eol) begin
        bcnt   <= 12'd0;
        pcnt   <= 10'd0;
        pair_x <= 10'd0;
      end
    end
  end

  // Per-frame accumulators and publish on vs rising edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lcnt <= 12'd0; phase_acc <= 1'b0; len_acc <= 1'b0; seen_fs <= 1'b0;
      frame_done <= 1'b0; frame_lines <= 12'd0; frame_ok <= 1'b0;
      phase_err <= 1'b0; len_err <= 1'b0;
    end else begin
      frame_done <= fs;
      if (fs) begin
        frame_lines <= lines_nxt;
        phase_err   <= phase_nxt;
        len_err     <= len_nxt;
        // the first publish after reset covers a partial frame
        frame_ok    <= seen_fs && (lines_nxt == V_EXP) && !phase_nxt && !len_nxt;
        seen_fs     <= 1'b1;
        lcnt        <= 12'd0;
        phase_acc   <= 1'b0;
        len_acc     <= 1'b0;
      end else begin
        lcnt      <= lines_nxt;
        phase_acc <= phase_nxt;
        len_acc   <= len_nxt;
      end
    end
  end

`ifdef RX_CHECKSUM_EN
  logic [15:0] sum_acc, sum_nxt;

  assign sum_nxt = sum_acc + (de_q ? {8'h00, data_q} : 16'h0000);

  // Wrap-around byte sum from one frame start to the next
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_acc  <= 16'h0000;
      checksum <= 16'h0000;
    end else if (fs) begin
      checksum <= sum_nxt;
      sum_acc  <= 16'h0000;
    end else begin
      sum_acc <= sum_nxt;
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_ycbcr422_rx.sv
// tb_ycbcr422_rx: randomized stimulus against a queue-based reference model
// (expected pairs and frame results derived from the bytes sent per line).
// Geometry is scaled down so every scenario fits in a few thousand cycles.
module tb_ycbcr422_rx;
  localparam int H = 16;
  localparam int V = 8;

  logic        clk = 1'b0, rst_n = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        pair_valid, frame_done, frame_ok, phase_err, len_err;
  logic [7:0]  pair_y0, pair_y1, pair_cb, pair_cr;
  logic [9:0]  pair_x;
  logic [8:0]  line_num;
  logic [11:0] frame_lines;
  logic [15:0] checksum;

  ycbcr422_rx #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de), .data(data),
    .pair_valid(pair_valid), .pair_y0(pair_y0), .pair_y1(pair_y1),
    .pair_cb(pair_cb), .pair_cr(pair_cr), .pair_x(pair_x),
    .line_num(line_num), .frame_done(frame_done), .frame_lines(frame_lines),
    .frame_ok(frame_ok), .phase_err(phase_err), .len_err(len_err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] y0, cb, y1, cr; int x, ln, c; } pair_t;
  typedef struct { int lines; bit ok, pe, le; logic [15:0] sum; int c; } frame_t;

  pair_t  pq[$];
  frame_t fq[$];

  // reference model state
  int          m_lines = 0, bi = 0;
  bit          m_pe = 0, m_le = 0, m_first = 1;
  logic [15:0] m_sum = 16'h0000;
  logic [7:0]  bb [4];
  logic [7:0]  pat [4];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_frame();
    frame_t f;
    f.lines = m_lines; f.pe = m_pe; f.le = m_le;
    f.ok = !m_first && (m_lines == V) && !m_pe && !m_le;
`ifdef RX_CHECKSUM_EN
    f.sum = m_sum;
`else
    f.sum = 16'h0000;
`endif
    f.c = cyc + 2;
    fq.push_back(f);
    m_lines = 0; m_pe = 0; m_le = 0; m_sum = 16'h0000; m_first = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pair_t p;
    hs = 1'b0; de = 1'b1; data = b;
    m_sum = m_sum + {8'h00, b};
    bb[bi % 4] = b;
    if (bi % 4 == 3) begin
      p.y0 = bb[0]; p.cb = bb[1]; p.y1 = bb[2]; p.cr = bb[3];
      p.x = bi / 4; p.ln = (m_lines > 511) ? 511 : m_lines; p.c = cyc + 2;
      pq.push_back(p);
    end
    bi++;
  endtask

  task automatic end_line();
    de = 1'b0; data = 8'h00; hs = 1'b1;
    m_lines++;
    if (bi % 4 != 0) m_pe = 1;
    if (bi != H)     m_le = 1;
    bi = 0;
  endtask

  task automatic drive_line(input int n, input bit rnd, input bit vs_end);
    for (int i = 0; i < n; i++) begin
      tick();
      send_byte(rnd ? 8'($urandom) : pat[i % 4]);
    end
    tick();
    end_line();
    if (vs_end) begin
      vs = 1'b1;
      push_frame();
      repeat (2) tick();
      vs = 1'b0;
    end
    repeat (1 + $urandom_range(0, 2)) tick();
  endtask

  task automatic do_vs();
    tick(); vs = 1'b1; push_frame();
    repeat (2) tick(); vs = 1'b0;
    repeat (2) tick();
  endtask

  // nl lines; line bad_idx (if >= 0) gets bad_n bytes instead of H
  task automatic frame(input int nl, input int bad_idx, input int bad_n, input bit rnd);
    for (int l = 0; l < nl; l++) drive_line((l == bad_idx) ? bad_n : H, rnd, 1'b0);
    do_vs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pair_valid"}, 32'(pair_valid), 0);
    chk({tag, "_pair_bytes"}, {pair_y0, pair_cb, pair_y1, pair_cr}, 0);
    chk({tag, "_pair_x"}, 32'(pair_x), 0);
    chk({tag, "_line_num"}, 32'(line_num), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_lines"}, 32'(frame_lines), 0);
    chk({tag, "_flags"}, {29'd0, frame_ok, phase_err, len_err}, 0);
    chk({tag, "_checksum"}, 32'(checksum), 0);
  endtask

  // Output monitor: every strobe is matched against the model queues
  always @(negedge clk) begin
    pair_t  p;
    frame_t f;
    if (pair_valid) begin
      if (pq.size() == 0) chk("pair_unexpected", 1, 0);
      else begin
        p = pq.pop_front();
        chk("pair_y0", 32'(pair_y0), 32'(p.y0));
        chk("pair_cb", 32'(pair_cb), 32'(p.cb));
        chk("pair_y1", 32'(pair_y1), 32'(p.y1));
        chk("pair_cr", 32'(pair_cr), 32'(p.cr));
        chk("pair_x", 32'(pair_x), p.x);
        chk("pair_line_num", 32'(line_num), p.ln);
        chk("pair_latency", cyc, p.c);
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) chk("frame_unexpected", 1, 0);
      else begin
        f = fq.pop_front();
        chk("frame_lines", 32'(frame_lines), f.lines);
        chk("frame_ok", 32'(frame_ok), 32'(f.ok));
        chk("phase_err", 32'(phase_err), 32'(f.pe));
        chk("len_err", 32'(len_err), 32'(f.le));
        chk("checksum", 32'(checksum), 32'(f.sum));
        chk("frame_latency", cyc, f.c);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat[0] = 8'h10; pat[1] = 8'h80; pat[2] = 8'h20; pat[3] = 8'h90;

    // reset state
    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset");
    tick(); rst_n = 1'b1;
    repeat (2) tick();

    do_vs();                          // partial first frame: ok must be 0
    frame(V, -1, 0, 1'b0);            // nominal pattern frame
    frame(V, -1, 0, 1'b1);            // nominal random-data frame
    frame(V, 7, H - 4, 1'b1);         // short last line
    frame(V, -1, 0, 1'b1);            // clean recovery
    frame(V, 3, H + 2, 1'b1);         // odd line: trailing bytes, no strobe
    frame(V - 1, -1, 0, 1'b1);        // one line too few
    frame(V + 1, -1, 0, 1'b1);        // one line too many

    // vs rising on the same pin cycle as the last de fall
    for (int l = 0; l < V; l++) drive_line(H, 1'b1, l == V - 1);

    // reset mid-line at byte 7 of line 3
    for (int l = 0; l < 3; l++) drive_line(H, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin tick(); send_byte(8'($urandom)); end
    tick(); rst_n = 1'b0; data = 8'($urandom);
    m_lines = 0; m_pe = 0; m_le = 0; m_sum = 16'h0000; m_first = 1; bi = 0;
    tick(); rst_n = 1'b1; send_byte(8'($urandom));
    @(negedge clk);
    chk_all_zero("midreset");
    for (int i = 1; i < H - 8; i++) begin tick(); send_byte(8'($urandom)); end
    tick(); end_line();
    repeat (2) tick();
    for (int l = 4; l < V; l++) drive_line(H, 1'b1, 1'b0);
    do_vs();                          // first publish after reset: ok = 0
    frame(V, -1, 0, 1'b1);            // following clean frame: ok = 1

    repeat (10) tick();
    chk("pairs_pending", pq.size(), 0);
    chk("frames_pending", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ycbcr422_rx.md
# ycbcr422_rx

Receive-side checker and unpacker for the 8-bit YCbCr 4:2:2 video stream (hs/vs/de/data) driven by the on-chip pattern generator or the camera path. It sits at the far end of that interface. It regroups the byte stream Y0,Cb,Y1,Cr into pixel pairs, counts active bytes per line and active lines per frame, and flags malformed lines and frames. It is used as the bring-up and self-test sink for OLED and camera paths.

## Interface
Parameters:
- H_ACTIVE, 1280, expected active bytes per line (de-high cycles per line); must be a multiple of 4.
- V_ACTIVE, 400, expected active lines per frame.

Ports:
- clk  in  1  pixel/byte clock.
- rst_n  in  1  reset. One clock, reset is synchronous and active-low.
- hs  in  1  line sync, active high. Carried in the input register only; not used for counting.
- vs  in  1  field sync, active high. Its rising edge starts a frame.
- de  in  1  data enable, one byte per cycle while high.
- data  in  8  stream byte.
- pair_valid  out  1  one-cycle strobe; the pair_* outputs are valid.
- pair_y0, pair_y1, pair_cb, pair_cr  out  8 each  unpacked pixel pair.
- pair_x  out  10  pair index within the line, starting at 0.
- line_num  out  9  active line index within the frame, starting at 0.
- frame_done  out  1  one-cycle strobe; the frame results below have just updated.
- frame_lines  out  12  active lines counted in the last completed frame.
- frame_ok  out  1  last frame matched H_ACTIVE/V_ACTIVE with no errors.
- phase_err  out  1  last frame had a line whose byte count was not a multiple of 4.
- len_err  out  1  last frame had a line whose byte count was not equal to H_ACTIVE.
- checksum  out  16  last frame checksum (see Configuration).

## Operation
- Input stage: hs, vs, de and data are registered once (hs_q, vs_q, de_q, data_q). All logic below works on the registered copies.
- Byte phase counter ph[1:0]:
  - Cleared while de_q is low.
  - Increments on each de_q-high cycle.
  - Phase 0 captures Y0, phase 1 Cb, phase 2 Y1, phase 3 Cr.
- Pair output: on the phase 3 byte, register all four bytes, pulse pair_valid, then increment pair_x.
- Line byte counter: 12 bits. Counts de_q-high cycles and saturates at 4095.
- End of line = de_q falling edge (de_q low, de_q delayed one cycle high). At end of line:
  - ph ≠ 0 sets sticky phase_acc.
  - byte count ≠ H_ACTIVE sets sticky len_acc.
  - line_num increments, saturating at 511.
  - pair_x and the byte counter clear.
- Frame start = vs_q rising edge. At frame start:
  - Copy the accumulators into the outputs: frame_lines = line_num count, phase_err, len_err, checksum.
  - frame_ok = (lines == V_ACTIVE) & !phase_acc & !len_acc.
  - Pulse frame_done.
  - Clear the accumulators, line_num and the checksum accumulator.
- First frame after reset: the first vs edge publishes an invalid partial frame with frame_ok = 0. The bench discards it.
- de rising while vs_q is high is legal and is counted normally.
- vs rising on the same cycle as an end of line: the end-of-line accounting happens first and is included in the published frame.
- Partial line at vs (de still high): that line is never closed. It is not counted and not error-checked. Its bytes carry into the next frame's first line.
- Reset (rst_n low at a clock edge) clears all registers; it may occur mid-line or mid-frame. Reset values: all outputs 0, including frame_ok = 0 and checksum = 0x0000.

## Timing
- Byte at the data pin in cycle N reaches data_q at N+1.
- For a Cr byte at the pin in cycle N, pair_valid and the pair_* outputs are high/valid in cycle N+2 for exactly one cycle.
- Pair strobes are spaced at least 4 cycles apart.
- vs pin rising at cycle N gives frame_done high at N+2. The frame outputs are stable from N+2 until the next frame_done.
- line_num and pair_x update in the cycle after the end-of-line detect.
- No backpressure: the block accepts one byte per cycle indefinitely.

## Configuration
- RX_CHECKSUM_EN defined:
  - 16-bit wrap-around sum of every de_q-high byte, zero-extended, accumulated from one frame start to the next.
  - Published on checksum at frame_done.
- RX_CHECKSUM_EN undefined:
  - The accumulator is not built and checksum is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- Nominal frame: 400 lines of 1280 bytes with repeating 0x10,0x80,0x20,0x90, vs between frames. Expect per line: 320 pair_valid, each with y0=0x10, cb=0x80, y1=0x20, cr=0x90, and pair_x from 0 to 319. Expect at the second vs: frame_lines=400, frame_ok=1, phase_err=0, len_err=0. With RX_CHECKSUM_EN: checksum = (400·320·0x140) mod 2^16 = 0x0000.
- Short line: line 7 has 1276 bytes. Expect len_err=1, phase_err=0, frame_ok=0. The next clean frame gives frame_ok=1.
- Odd line: line 3 has 1282 bytes. Expect phase_err=1 and len_err=1. The last pair of that line is strobed, and the two trailing bytes produce no strobe.
- Line count: frame of 399 lines. Expect frame_lines=399, frame_ok=0. Frame of 401 lines: expect frame_lines=401, frame_ok=0.
- Latency/simultaneity: vs rises on the same pin cycle as the de fall of the last line. Expect frame_done two cycles later with frame_lines=400 (last line included).
- Reset mid-line: drop rst_n for 1 cycle at byte 600 of line 100. Expect all outputs at 0 in the next cycle. The first frame after that is published with frame_ok=0, and the following clean frame gives frame_ok=1.
